// File: rtl/sba_pkg.sv
// sba_pkg: shared types and helpers for the SBA burst master.
//   - sba_state_e   : FSM state encoding (IDLE, CHECK, REQ, WAIT)
//   - SBA_ERR_*     : sberror_o codes
//   - sba_max_size  : largest legal log2(bytes) for a given bus width
//   - sba_align_mask: low address bits that must be zero for a size
package sba_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_WAIT  = 2'd3
  } sba_state_e;

  localparam logic [2:0] SBA_ERR_NONE    = 3'd0;
  localparam logic [2:0] SBA_ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] SBA_ERR_BUS     = 3'd2;
  localparam logic [2:0] SBA_ERR_ALIGN   = 3'd3;
  localparam logic [2:0] SBA_ERR_SIZE    = 3'd4;

  // Accesses are capped at 64 bits (sbdata width) and at the bus width.
  function automatic logic [2:0] sba_max_size(input int unsigned data_width);
    int unsigned bytes;
    bytes = ((data_width < 64) ? data_width : 64) / 8;
    if (bytes >= 8)      return 3'd3;
    else if (bytes >= 4) return 3'd2;
    else if (bytes >= 2) return 3'd1;
    else                 return 3'd0;
  endfunction

  function automatic logic [2:0] sba_align_mask(input logic [2:0] size);
    case (size)
      3'd0:    return 3'b000;
      3'd1:    return 3'b001;
      3'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/sba_burst_master_if.sv
// sba_mem_if: req/gnt/rvalid memory port between the SBA master and the
// interconnect adapter.
//   master: drives req, we, addr, wdata, be; receives gnt, rvalid, err, rdata
//   slave : the mirror image
interface sba_mem_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                    req;
  logic                    we;
  logic                    gnt;
  logic                    rvalid;
  logic                    err;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [DATA_WIDTH/8-1:0] be;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, err, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/sba_lane_align.sv
// sba_lane_align: combinational byte-lane steering for the SBA master.
//   offset_i : byte offset of the access within the bus word
//   size_i   : log2 of access bytes (values above 3 are treated as 3)
//   wdata_i  : right-aligned write data   -> wdata_o : replicated on the bus
//   rdata_i  : bus read data               -> rdata_o : right-aligned, zero-extended
//   be_o     : byte enables for the access
module sba_lane_align #(
  parameter  int DATA_WIDTH = 64,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int OW         = $clog2(NB)
) (
  input  logic [OW-1:0]         offset_i,
  input  logic [2:0]            size_i,
  input  logic [63:0]           wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [NB-1:0]         be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [63:0]           rdata_o
);

  logic [1:0]            sz;
  int                    nbytes;
  logic [DATA_WIDTH-1:0] shifted;
  logic [63:0]           lo;

  assign sz     = (size_i > 3'd3) ? 2'd3 : size_i[1:0];
  assign nbytes = 1 << sz;

  // Each bus byte lane carries the data byte at (lane mod access bytes), so
  // the access chunk appears in every naturally aligned slot of the bus.
  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    for (int i = 0; i < NB; i++) begin
      be_o[i]          = (i >= int'(offset_i)) && (i < int'(offset_i) + nbytes);
      wdata_o[8*i +: 8] = wdata_i[8*(i & (nbytes - 1)) +: 8];
    end
  end

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    lo      = 64'(shifted);
    case (sz)
      2'd0:    rdata_o = lo & 64'h0000_0000_0000_00FF;
      2'd1:    rdata_o = lo & 64'h0000_0000_0000_FFFF;
      2'd2:    rdata_o = lo & 64'h0000_0000_FFFF_FFFF;
      default: rdata_o = lo;
    endcase
  end

endmodule

// File: rtl/sba_burst_master.sv
// sba_burst_master: turns debugger SBA commands into req/gnt/rvalid bus
// transactions with multi-beat read bursts, size/alignment checks and lane
// steering.
//   clk_i, rst_ni, dmactive_i : clock, sync active-low reset, sync clear
//   sb*_i                     : SBA CSR command/data inputs
//   sbaddress_o, sbdata_o     : updated address, right-aligned read data
//   sbdata_valid_o            : pulse per read beat / write completion
//   sbbusy_o                  : FSM not idle
//   sberror_valid_o/sberror_o : error pulse and code
//   mem                       : memory port (sba_mem_if.master)
// Optional feature: define SBA_TIMEOUT_EN to enable the response timeout.
module sba_burst_master
  import sba_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int BURST_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   dmactive_i,
  input  logic [ADDR_WIDTH-1:0]  sbaddress_i,
  input  logic                   sbaddress_write_valid_i,
  input  logic                   sbreadonaddr_i,
  input  logic                   sbautoincrement_i,
  input  logic [2:0]             sbaccess_i,
  input  logic [BURST_WIDTH-1:0] sbburst_len_i,
  input  logic                   sbreadondata_i,
  input  logic [63:0]            sbdata_i,
  input  logic                   sbdata_read_valid_i,
  input  logic                   sbdata_write_valid_i,
  output logic [ADDR_WIDTH-1:0]  sbaddress_o,
  output logic [63:0]            sbdata_o,
  output logic                   sbdata_valid_o,
  output logic                   sbbusy_o,
  output logic                   sberror_valid_o,
  output logic [2:0]             sberror_o,
  sba_mem_if.master              mem
);

  localparam int         NB       = DATA_WIDTH / 8;
  localparam int         OW       = $clog2(NB);
  localparam logic [2:0] MAX_SIZE = sba_max_size(DATA_WIDTH);

  sba_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [2:0]             size_q, size_d;
  logic                   we_q, we_d;
  logic [63:0]            data_q, data_d;
  logic [BURST_WIDTH-1:0] beats_q, beats_d;
  logic                   autoinc_q, autoinc_d;
  logic [63:0]            rdata_q, rdata_d;
  logic                   req_q, req_d;
  logic                   dvalid_q, dvalid_d;
  logic                   busy_q, busy_d;
  logic                   errv_q, errv_d;
  logic [2:0]             err_q, err_d;

  logic                   start_wr, start_rd, tmo_hit;
  logic [63:0]            lane_rdata;
  logic [NB-1:0]          lane_be;
  logic [DATA_WIDTH-1:0]  lane_wdata;

`ifdef SBA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign start_wr = sbdata_write_valid_i;
  assign start_rd = (sbaddress_write_valid_i && sbreadonaddr_i) ||
                    (sbdata_read_valid_i && sbreadondata_i);

  sba_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .offset_i (addr_q[OW-1:0]),
    .size_i   (size_q),
    .wdata_i  (data_q),
    .rdata_i  (mem.rdata),
    .be_o     (lane_be),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

  // Errors are decided at accept time and shown during CHECK, so the pulse
  // lands one cycle after the start strobe. Bus and timeout errors also
  // route through CHECK so every error pulse precedes the return to IDLE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    we_d      = we_q;
    data_d    = data_q;
    beats_d   = beats_q;
    autoinc_d = autoinc_q;
    rdata_d   = rdata_q;
    dvalid_d  = 1'b0;
    errv_d    = 1'b0;
    err_d     = SBA_ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (start_wr || start_rd) begin
          state_d   = ST_CHECK;
          addr_d    = sbaddress_i;
          size_d    = sbaccess_i;
          we_d      = start_wr;
          data_d    = sbdata_i;
          autoinc_d = sbautoincrement_i;
          beats_d   = (start_wr || sbburst_len_i == '0) ? BURST_WIDTH'(1) : sbburst_len_i;
          if (sbaccess_i > MAX_SIZE) begin
            errv_d = 1'b1;
            err_d  = SBA_ERR_SIZE;
          end else if ((sbaddress_i[2:0] & sba_align_mask(sbaccess_i)) != 3'b000) begin
            errv_d = 1'b1;
            err_d  = SBA_ERR_ALIGN;
          end
        end
      end
      ST_CHECK: state_d = errv_q ? ST_IDLE : ST_REQ;
      ST_REQ: begin
        if (mem.gnt) begin
          state_d = ST_WAIT;
        end else if (tmo_hit) begin
          state_d = ST_CHECK;
          errv_d  = 1'b1;
          err_d   = SBA_ERR_TIMEOUT;
        end
      end
      ST_WAIT: begin
        if (mem.rvalid) begin
          if (mem.err) begin
            state_d = ST_CHECK;
            errv_d  = 1'b1;
            err_d   = SBA_ERR_BUS;
          end else begin
            dvalid_d = 1'b1;
            if (!we_q)     rdata_d = lane_rdata;
            if (autoinc_q) addr_d  = addr_q + (ADDR_WIDTH'(1) << size_q);
            beats_d = beats_q - BURST_WIDTH'(1);
            state_d = (beats_q > BURST_WIDTH'(1)) ? ST_REQ : ST_IDLE;
          end
        end else if (tmo_hit) begin
          state_d = ST_CHECK;
          errv_d  = 1'b1;
          err_d   = SBA_ERR_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d  = (state_d == ST_REQ);
    busy_d = (state_d != ST_IDLE);
`ifdef SBA_TIMEOUT_EN
    // Counter restarts on every entry to REQ or WAIT.
    tmo_d = tmo_q + TW'(1);
    if ((state_d != state_q) || !(state_d inside {ST_REQ, ST_WAIT})) tmo_d = '0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !dmactive_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      data_q    <= '0;
      beats_q   <= '0;
      autoinc_q <= 1'b0;
      rdata_q   <= '0;
      req_q     <= 1'b0;
      dvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      errv_q    <= 1'b0;
      err_q     <= SBA_ERR_NONE;
`ifdef SBA_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      we_q      <= we_d;
      data_q    <= data_d;
      beats_q   <= beats_d;
      autoinc_q <= autoinc_d;
      rdata_q   <= rdata_d;
      req_q     <= req_d;
      dvalid_q  <= dvalid_d;
      busy_q    <= busy_d;
      errv_q    <= errv_d;
      err_q     <= err_d;
`ifdef SBA_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign sbaddress_o     = addr_q;
  assign sbdata_o        = rdata_q;
  assign sbdata_valid_o  = dvalid_q;
  assign sbbusy_o        = busy_q;
  assign sberror_valid_o = errv_q;
  assign sberror_o       = err_q;

  // Latched command fields are frozen outside IDLE, so the bus side stays
  // stable for the whole request; we/be are gated to read as zero when idle.
  assign mem.req   = req_q;
  assign mem.we    = we_q & req_q;
  assign mem.addr  = addr_q & ~ADDR_WIDTH'(NB - 1);
  assign mem.be    = req_q ? lane_be : '0;
  assign mem.wdata = lane_wdata;

endmodule
